// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus of the program loader.
interface imem_loader_if #(
  parameter int unsigned AW = 6
);
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;

  // Stream source / imem sink side.
  modport master (
    output in_data, in_valid,
    input  in_ready, we, waddr, wdata
  );

  // Loader side.
  modport slave (
    input  in_data, in_valid,
    output in_ready, we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: takes a length header plus MSB-first instruction bytes
// and writes 32-bit words into imem from word 0, holding the CPU in reset
// until the whole image has been written.
module imem_loader #(
  parameter int unsigned MMDATA = 64,
  parameter int unsigned AW     = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_reset_n
);

  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t        state_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] idx_q;
  logic [1:0]    lane_q;
  logic [23:0]   shift_q;
  logic          fin_q;
  logic          in_ready_q;
  logic          we_q;
  logic [AW-1:0] waddr_q;
  logic [31:0]   wdata_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          cpu_reset_n_q;

  logic          accept;
  logic [CW-1:0] hdr_cnt;
  logic          last_word;

  // Handshake and header/word-index helpers.
  assign accept    = bus.in_valid & in_ready_q;
  assign hdr_cnt   = {count_q[15:8], bus.in_data};
  assign last_word = (CW'(idx_q) == (count_q - CW'(1)));

  // Loader FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      idx_q         <= '0;
      lane_q        <= '0;
      shift_q       <= '0;
      fin_q         <= 1'b0;
      in_ready_q    <= 1'b0;
      we_q          <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      cpu_reset_n_q <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q       <= LEN_HI;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            idx_q         <= '0;
            lane_q        <= '0;
            fin_q         <= 1'b0;
            busy_q        <= 1'b1;
            cpu_reset_n_q <= 1'b0;
            in_ready_q    <= 1'b1;
          end
        end
        LEN_HI: begin
          if (accept) begin
            count_q[15:8] <= bus.in_data;
            state_q       <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            count_q[7:0] <= bus.in_data;
            if (hdr_cnt == '0 || hdr_cnt > CW'(MMDATA)) begin
              // Empty or oversized image: finish without touching imem.
              state_q       <= DONE;
              err_q         <= (hdr_cnt != '0);
              in_ready_q    <= 1'b0;
              busy_q        <= 1'b0;
              done_q        <= 1'b1;
              cpu_reset_n_q <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (fin_q) begin
            // Final word was written last cycle; release the CPU now.
            state_q       <= DONE;
            fin_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            cpu_reset_n_q <= 1'b1;
          end else if (accept) begin
            lane_q  <= lane_q + 2'd1;
            shift_q <= {shift_q[15:0], bus.in_data};
            if (lane_q == 2'd3) begin
              we_q    <= 1'b1;
              waddr_q <= idx_q;
              wdata_q <= {shift_q, bus.in_data};
              idx_q   <= idx_q + AW'(1);
              if (last_word) begin
                // Stop consuming: the image is complete.
                fin_q      <= 1'b1;
                in_ready_q <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // Drive the bus and status ports from their registers.
  assign bus.in_ready = in_ready_q;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign cpu_reset_n  = cpu_reset_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  logic clk;
  logic rst_n;
  logic start;
  logic busy, done, err, cpu_reset_n;

  imem_loader_if #(.AW(6)) bus ();

  imem_loader #(.MMDATA(64), .AW(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .cpu_reset_n (cpu_reset_n)
  );

  int          n_vec;
  int          n_err;
  int          wr_cnt;
  wr_t         sb[$];
  logic [31:0] img[64];
  logic [31:0] mem[64];
  logic [31:0] saved[64];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every imem write must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && bus.we === 1'b1) begin
      wr_t e;
      wr_cnt++;
      mem[bus.waddr] = bus.wdata;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL unexpected_we observed=%0h:%0h expected=none", bus.waddr, bus.wdata);
      end else begin
        e = sb.pop_front();
        check("we_addr", 64'(bus.waddr), 64'(e.a));
        check("we_data", 64'(bus.wdata), 64'(e.d));
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one byte and wait (bounded) until it is accepted at a posedge.
  task automatic send_byte(input logic [7:0] b, input bit strt);
    int t;
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    start        = strt;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      start = 1'b0;
      t++;
    end
    if (t >= 100) begin
      n_vec++;
      n_err++;
      $error("FAIL accept_timeout observed=in_ready_low expected=in_ready_high");
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Stream header plus n words of img, optionally with gaps; start pulsed at data byte sp.
  task automatic send_image(input int n, input bit gap, input int sp);
    logic [15:0] h;
    logic [31:0] wd;
    int          w0;
    h  = 16'(n);
    w0 = wr_cnt;
    pulse_start();
    check("busy_after_start", 64'({busy, cpu_reset_n, done}), 64'(3'b100));
    send_byte(h[15:8], 1'b0);
    send_byte(h[7:0], 1'b0);
    if (n == 0 || n > 64) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("hdr_done", 64'({done, busy, cpu_reset_n, bus.in_ready}), 64'(4'b1010));
      check("hdr_err", 64'(err), 64'(n > 64));
    end else begin
      for (int w = 0; w < n; w++) begin
        wd = img[w];
        for (int b = 0; b < 4; b++) begin
          if (b == 3) sb.push_back('{a: 6'(w), d: img[w]});
          send_byte(wd[31:24], (w * 4 + b) == sp);
          wd = wd << 8;
          if (gap) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
          end
        end
      end
      if (!gap) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      check("done_not_early", 64'({done, cpu_reset_n, busy}), 64'(3'b001));
      @(negedge clk);
      check("done_after_last", 64'({done, cpu_reset_n, busy, err}), 64'(4'b1100));
      check("sb_drained", 64'(sb.size()), 64'd0);
    end
    check("write_count", 64'(wr_cnt - w0), 64'((n > 64) ? 0 : n));
    check("in_ready_done", 64'(bus.in_ready), 64'd0);
  endtask

  initial begin
    int bad;
    n_vec        = 0;
    n_err        = 0;
    wr_cnt       = 0;
    start        = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({bus.in_ready, bus.we, bus.waddr, bus.wdata, busy, done, err, cpu_reset_n}),
          64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Two-word image.
    img[0] = 32'h24080005;
    img[1] = 32'h00000000;
    send_image(2, 1'b0, -1);
    check("mem0", 64'(mem[0]), 64'h24080005);

    // Zero-length header.
    send_image(0, 1'b0, -1);

    // Oversized header; bytes offered afterwards are not consumed.
    send_image(65, 1'b0, -1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    repeat (3) @(negedge clk);
    check("no_consume_done", 64'({bus.in_ready, busy, done, err}), 64'(4'b0011));
    bus.in_valid = 1'b0;

    // Three words with valid toggled every other cycle.
    for (int i = 0; i < 3; i++) img[i] = $urandom;
    send_image(3, 1'b1, -1);

    // Reset after six data bytes, then full reload.
    img[0] = 32'hDEADBEEF;
    img[1] = 32'h12345678;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    sb.push_back('{a: 6'd0, d: 32'hDEADBEEF});
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    #2;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset",
          64'({bus.in_ready, bus.we, bus.waddr, bus.wdata, busy, done, err, cpu_reset_n}),
          64'(0));
    check("sb_word0_written", 64'(sb.size()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    img[0] = 32'h24080005;
    img[1] = 32'hAC0A0004;
    send_image(2, 1'b0, -1);
    check("reload_mem1", 64'(mem[1]), 64'hAC0A0004);

    // Full-depth image with a start pulse mid-stream, then restart from DONE.
    for (int i = 0; i < 64; i++) img[i] = $urandom;
    send_image(64, 1'b0, 101);
    for (int i = 0; i < 64; i++) saved[i] = img[i];
    img[0] = 32'h11111111;
    img[1] = 32'h22222222;
    send_image(2, 1'b0, -1);
    bad = 0;
    for (int i = 2; i < 64; i++) if (mem[i] !== saved[i]) bad++;
    check("imem_untouched", 64'(bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
